// File: rtl/muldiv_sequencer.sv
// Multi-cycle integer multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one iteration per RUN cycle, WIDTH iterations per operation. The signs
// are fixed up on the edge that writes HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;       // 1: divide, 0: multiply
  logic               neg_lo_q, neg_lo_d; // negate product / quotient
  logic               neg_hi_q, neg_hi_d; // negate remainder
  logic               dz_q, dz_d;         // divide by zero seen at start
  logic [WIDTH-1:0]   a_q, a_d;           // raw dividend, HI on divide by zero
  logic [WIDTH-1:0]   b_q, b_d;           // multiplicand / divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial product|remainder, multiplier|quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               start;
  logic               last;
  logic               s_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, prod;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes and one shift-add / restoring-subtract step
  always_comb begin
    s_op   = ~OpE[0];
    a_neg  = s_op & SrcAE[WIDTH-1];
    b_neg  = s_op & SrcBE[WIDTH-1];
    a_mag  = a_neg ? -SrcAE : SrcAE;
    b_mag  = b_neg ? -SrcBE : SrcBE;

    // Multiply: add multiplicand into the upper half when the low bit is set,
    // then shift the whole accumulator right (carry enters at the top).
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    prod    = neg_lo_q ? -mul_nxt : mul_nxt;

    // Divide: shift next dividend bit into the remainder, keep the
    // difference only if it did not go negative.
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, b_q};
    div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
    quo     = neg_lo_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
    rem     = neg_hi_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
  end

  // Sequencer next state, operand capture and result write
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    start = (state_q != RUN) && StartE && !Cancel;
    last  = (cnt_q == CW'(WIDTH - 1));

    case (state_q)
      RUN: begin
        if (Cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          acc_d = div_q ? div_nxt : mul_nxt;
          if (last) begin
            state_d = DONE;
            if (!div_q) begin
              {hi_d, lo_d} = prod;
            end else if (dz_q) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start from IDLE or DONE overrides the default return to IDLE
    if (start) begin
      state_d  = RUN;
      cnt_d    = '0;
      div_d    = OpE[1];
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = a_neg;
      dz_d     = OpE[1] && (SrcBE == '0);
      a_d      = SrcAE;
      b_d      = b_mag;
      acc_d    = {{WIDTH{1'b0}}, a_mag};
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign DivZero = Done && dz_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes the expected
// result and Done cycle, a monitor pops and compares on every Done.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RST, StartE, Cancel;
  logic [1:0]  OpE;
  logic [31:0] SrcAE, SrcBE;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE),
    .SrcBE(SrcBE), .Cancel(Cancel), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_hi = 0, last_lo = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the architectural values
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, q, r;
    logic [63:0] p;
    e.dz = 1'b0;
    e.cyc = 0;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb_); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          e.dz = 1'b1; e.hi = a; e.lo = 32'hFFFFFFFF;
        end else if (op == 2'b10) begin
          q = sa / sb_; r = sa % sb_;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (DivZero && !Done) check("divzero_without_done", 1, 0);
    if (Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", HI, e.hi);
        check("lo", LO, e.lo);
        check("divzero", DivZero, e.dz);
        check("done_cycle", cyc, e.cyc);
        check("busy_with_done", Busy, 0);
      end
    end
  end

  // Drive a start in the current cycle; optionally register the expectation
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    if (push) begin
      e = model(op, a, b);
      e.cyc = cyc + 33;
      sb.push_back(e);
      last_hi = e.hi; last_lo = e.lo;
    end
  endtask

  // Advance until Done is visible (cycle 33), scrambling the inputs meanwhile
  task automatic wait_done(input int exp_bc);
    int  bc = 0;
    bit  seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge CLK); #1;
      StartE = 1'b0;
      OpE = 2'($urandom); SrcAE = $urandom; SrcBE = $urandom;
      if (Done) seen = 1;
      else if (Busy) bc++;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end else if (exp_bc >= 0) begin
      check("busy_cycles", bc, exp_bc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; StartE = 1'b0; end
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RST = 1'b1; StartE = 1'b0; Cancel = 1'b0; OpE = 2'b00; SrcAE = 0; SrcBE = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hilo", {HI, LO}, 64'h0);
    RST = 1'b0;
    idle(2);

    // Directed vectors
    issue(2'b01, 32'hFFFFFFFF, 32'h2, 1); wait_done(32); idle(1);
    issue(2'b00, 32'hFFFFFFFD, 32'h5, 1); wait_done(32); idle(1);
    issue(2'b10, 32'hFFFFFFF9, 32'h2, 1); wait_done(32); idle(1);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1); wait_done(32); idle(1);
    issue(2'b11, 32'h7, 32'h0, 1); wait_done(32); idle(1);

    // StartE during RUN is ignored; the monitor flags any extra Done
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 1);
    idle(5);
    issue(2'b11, 32'hDEAD, 32'h3, 0);
    wait_done(-1);
    // Back-to-back start in the DONE cycle
    issue(2'b10, 32'h80000001, 32'h7, 1); wait_done(32);
    issue(2'b11, 32'd100, 32'd7, 1); wait_done(32); idle(3);
    check("queue_drained_b2b", sb.size(), 0);

    // Cancel in RUN cycle 10
    issue(2'b11, 32'd100, 32'd7, 0);
    idle(10);
    Cancel = 1'b1;
    @(posedge CLK); #1;
    Cancel = 1'b0;
    check("cancel_busy", Busy, 0);
    idle(40);
    check("cancel_hilo", {HI, LO}, {last_hi, last_lo});

    // Cancel wins over StartE
    issue(2'b01, 32'h5, 32'h6, 0);
    Cancel = 1'b1;
    @(posedge CLK); #1;
    StartE = 1'b0; Cancel = 1'b0;
    check("cancel_prio_busy", Busy, 0);
    idle(36);
    check("cancel_prio_hilo", {HI, LO}, {last_hi, last_lo});

    // Reset in RUN cycle 20
    issue(2'b01, 32'hFFFF0000, 32'h0000FFFF, 0);
    idle(20);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_run_hilo", {HI, LO}, 64'h0);
    check("rst_run_busy", Busy, 0);
    last_hi = 0; last_lo = 0;
    idle(40);

    // Randomized operations, some chained back-to-back
    for (int k = 0; k < 60; k++) begin
      issue(2'($urandom), rval(), rval(), 1);
      wait_done(32);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
    check("queue_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: StartE  input  1  EX-stage request to begin an operation.
REQ-005 SHALL have port: OpE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: SrcAE  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port: SrcBE  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port: Cancel  input  1  abort the current or requested operation (pipeline flush).
REQ-009 SHALL have port: Busy  output  1  operation in progress; the hazard unit stalls F/D and holds E on it.
REQ-010 SHALL have port: Done  output  1  one-cycle pulse, result valid on HI/LO.
REQ-011 SHALL have port: DivZero  output  1  one-cycle pulse with Done when a DIV/DIVU divisor was zero.
REQ-012 SHALL have port: HI  output  WIDTH  product upper half / remainder.
REQ-013 SHALL have port: LO  output  WIDTH  product lower half / quotient.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; Busy=1 only in RUN, Done=1 only in DONE.
REQ-015 SHALL accept a start in IDLE or DONE when StartE=1 and Cancel=0: latch operands and OpE, clear the 6-bit iteration counter, go to RUN.
REQ-016 SHALL ignore StartE while in RUN; it is neither queued nor counted.
REQ-017 SHALL do one iteration per RUN cycle, exactly WIDTH (32) RUN cycles, then go to DONE; start sampled at edge 0 -> Busy cycles 1..32 -> Done in cycle 33.
REQ-018 SHALL write HI/LO on the edge leaving the last RUN cycle; HI/LO SHALL hold their value at all other times.
REQ-019 SHALL go from DONE to IDLE after one cycle unless a new start is accepted (DONE -> RUN).
REQ-020 SHALL multiply by radix-2 shift-add on operand magnitudes; MULT SHALL give the signed 64-bit product {HI,LO}, MULTU the unsigned one.
REQ-021 SHALL divide by radix-2 restoring division on magnitudes: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (DIV); unsigned for DIVU.
REQ-022 SHALL produce LO=0x80000000, HI=0 for DIV 0x80000000 / 0xFFFFFFFF, with no flag.
REQ-023 SHALL detect divisor==0 at start, keep the normal 32-cycle latency, then force LO=0xFFFFFFFF, HI=SrcAE, and pulse DivZero with Done.
REQ-024 SHALL handle Cancel=1 in RUN by going to IDLE next cycle, with no Done and no HI/LO update.
REQ-025 SHALL give Cancel priority over StartE in the same cycle, so no operation starts.
REQ-026 SHALL keep datapath registers (accumulator, shifted operands, counter) internal; only HI/LO/Done/DivZero/Busy are observable.

Reset
REQ-027 SHALL, on RST=1 at a rising edge, force state=IDLE, counter=0, HI=0, LO=0, Busy=0, Done=0, DivZero=0.
REQ-028 SHALL let RST abort an operation mid-RUN with no Done pulse; RST SHALL override StartE and Cancel.

Verification
REQ-029 SHALL pass: MULTU 0xFFFFFFFF x 0x00000002 -> Busy cycles 1..32, Done in cycle 33, HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 SHALL pass: MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-031 SHALL pass: DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7, DivZero=1 with Done in cycle 33.
REQ-032 SHALL pass: start DIVU 100/7, Cancel in RUN cycle 10 -> Busy=0 from cycle 11, no Done, HI/LO keep prior values.
REQ-033 SHALL pass: StartE pulsed during RUN is ignored; back-to-back start in the DONE cycle -> second result in Done exactly 33 cycles later.
REQ-034 SHALL pass: RST asserted in RUN cycle 20 -> next cycle HI=LO=0, Busy=0, no Done.
